// File: rtl/lut_neuron_rt_if.sv
// Handshake, output and table-configuration bundle for one run-time programmable LUT neuron.
// The master side drives lookups and table writes; the slave side is the neuron itself.
interface lut_neuron_rt_if #(
  parameter int ADDR_W   = 6,
  parameter int OUT_BITS = 2
);
  logic                in_valid;
  logic                in_ready;
  logic [ADDR_W-1:0]   in_data;
  logic                out_valid;
  logic                out_ready;
  logic [OUT_BITS-1:0] out_data;
  logic                cfg_we;
  logic [ADDR_W-1:0]   cfg_addr;
  logic [OUT_BITS-1:0] cfg_data;
  logic                table_loaded;

  modport master (
    output in_valid, in_data, out_ready, cfg_we, cfg_addr, cfg_data,
    input  in_ready, out_valid, out_data, table_loaded
  );

  modport slave (
    input  in_valid, in_data, out_ready, cfg_we, cfg_addr, cfg_data,
    output in_ready, out_valid, out_data, table_loaded
  );
endinterface

// File: rtl/lut_neuron_rt.sv
// Run-time loadable LogicNets neuron: a DEPTH-entry truth table behind a 2-stage valid/ready pipeline.
// Stage 1 registers the input vector, stage 2 registers the table lookup of that vector.
module lut_neuron_rt #(
  parameter int FANIN    = 3,
  parameter int IN_BITS  = 2,
  parameter int OUT_BITS = 2,
  parameter int AUTO_INC = 1,
  parameter int GATE_OUT = 1
) (
  input logic            clk,
  input logic            rst_n,
  lut_neuron_rt_if.slave bus
);
  localparam int ADDR_W = FANIN * IN_BITS;
  localparam int DEPTH  = 1 << ADDR_W;

  logic [OUT_BITS-1:0] r_table [DEPTH];

  logic                r_s1_valid;
  logic [ADDR_W-1:0]   r_s1_addr;
  logic                r_out_valid;
  logic [OUT_BITS-1:0] r_out_data;
  logic [ADDR_W-1:0]   r_wr_ptr;
  logic                r_loaded;

  logic                w_adv;
  logic                w_wrap;
  logic [ADDR_W-1:0]   w_wr_addr;
  logic [OUT_BITS-1:0] w_rd_data;

  // Both stages move together whenever the output register is empty or being drained.
  assign w_adv     = !r_out_valid || bus.out_ready;
  assign w_wrap    = (r_wr_ptr == ADDR_W'(DEPTH - 1));
  assign w_wr_addr = (AUTO_INC != 0) ? r_wr_ptr : bus.cfg_addr;
  assign w_rd_data = r_table[r_s1_addr];

  assign bus.in_ready     = w_adv;
  assign bus.out_valid    = r_out_valid;
  assign bus.out_data     = r_out_data;
  assign bus.table_loaded = r_loaded;

  // NOTE: the table has no reset so it maps onto distributed LUT RAM; the
  // non-blocking write also means a same-edge read in stage 2 sees the old entry.
  always_ff @(posedge clk) begin
    if (bus.cfg_we) r_table[w_wr_addr] <= bus.cfg_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid  <= 1'b0;
      r_s1_addr   <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_wr_ptr    <= '0;
      r_loaded    <= 1'b0;
    end else begin
      if (w_adv) begin
        r_s1_valid  <= bus.in_valid;
        r_s1_addr   <= bus.in_data;
        r_out_valid <= r_s1_valid;
        r_out_data  <= (GATE_OUT != 0 && !r_loaded) ? '0 : w_rd_data;
      end
      // Writes are independent of the handshake and are honoured during stalls.
      if (bus.cfg_we) begin
        r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
        if (AUTO_INC == 0 || w_wrap) r_loaded <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_lut_neuron_rt.sv
// Directed bench for lut_neuron_rt (FANIN=3, IN_BITS=2, OUT_BITS=2, AUTO_INC=1, GATE_OUT=1).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_lut_neuron_rt;
  logic clk;
  logic rst_n;
  int   n_vec  = 0;
  int   n_fail = 0;

  lut_neuron_rt_if #(.ADDR_W(6), .OUT_BITS(2)) bus ();

  lut_neuron_rt #(
    .FANIN(3), .IN_BITS(2), .OUT_BITS(2), .AUTO_INC(1), .GATE_OUT(1)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle's worth of inputs, then wait for the next falling edge.
  task automatic cyc(input logic v, input logic [5:0] d, input logic ordy,
                     input logic we, input logic [1:0] wd);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.out_ready = ordy;
    bus.cfg_we    = we;
    bus.cfg_addr  = 6'd0;
    bus.cfg_data  = wd;
    @(negedge clk);
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    bus.cfg_we    = 1'b0;
    bus.cfg_addr  = '0;
    bus.cfg_data  = '0;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_table_loaded", bus.table_loaded, 0);
    check("rst_in_ready", bus.in_ready, 1);
    rst_n = 1'b1;

    // 1: lookup before any load is gated to 0, latency 2
    cyc(1, 6'h05, 1, 0, 0);
    check("t1_lat1_valid", bus.out_valid, 0);
    cyc(0, 6'h00, 1, 0, 0);
    check("t1_valid", bus.out_valid, 1);
    check("t1_data_gated", bus.out_data, 0);
    cyc(0, 6'h00, 1, 0, 0);
    check("t1_drained", bus.out_valid, 0);

    // 2: load table[i] = i%4 through the auto-increment pointer
    for (int i = 0; i < 64; i++) begin
      cyc(0, 6'h00, 1, 1, i[1:0]);
      if (i == 62) check("t2_loaded_after_63", bus.table_loaded, 0);
    end
    check("t2_loaded_after_64", bus.table_loaded, 1);

    // Back-to-back lookups 0..63: output i%4 appears two edges after input i
    for (int i = 0; i < 64; i++) begin
      cyc(1, i[5:0], 1, 0, 0);
      if (i == 0) begin
        check("t2_first_lat", bus.out_valid, 0);
      end else begin
        check("t2_stream_valid", bus.out_valid, 1);
        check("t2_stream_data", bus.out_data, (i - 1) % 4);
      end
    end
    cyc(0, 6'h00, 1, 0, 0);
    check("t2_last_valid", bus.out_valid, 1);
    check("t2_last_data", bus.out_data, 3);
    cyc(0, 6'h00, 1, 0, 0);
    check("t2_drained", bus.out_valid, 0);

    // 3: backpressure for 5 cycles mid-stream (inputs 10,11,12,13 -> 2,3,0,1)
    cyc(1, 6'd10, 1, 0, 0);
    cyc(1, 6'd11, 1, 0, 0);
    check("t3_pre_data", bus.out_data, 2);
    bus.in_data   = 6'd12;
    bus.out_ready = 1'b0;
    #1;
    check("t3_in_ready_low", bus.in_ready, 0);
    for (int k = 0; k < 5; k++) begin
      cyc(1, 6'd12, 0, 0, 0);
      check("t3_stall_valid", bus.out_valid, 1);
      check("t3_stall_data", bus.out_data, 2);
    end
    cyc(1, 6'd12, 1, 0, 0);
    check("t3_rel_data11", bus.out_data, 3);
    cyc(1, 6'd13, 1, 0, 0);
    check("t3_rel_data12", bus.out_data, 0);
    cyc(0, 6'd0, 1, 0, 0);
    check("t3_rel_data13", bus.out_data, 1);
    check("t3_rel_valid13", bus.out_valid, 1);
    cyc(0, 6'd0, 1, 0, 0);
    check("t3_no_dup", bus.out_valid, 0);

    // 6: 65th write lands on entry 0 after the wrap
    cyc(0, 6'd0, 1, 1, 2'b11);
    check("t6_loaded_stays", bus.table_loaded, 1);
    cyc(1, 6'd0, 1, 0, 0);
    cyc(0, 6'd0, 1, 0, 0);
    check("t6_entry0_valid", bus.out_valid, 1);
    check("t6_entry0_data", bus.out_data, 3);

    // 4: rewrite entry 7 on the same edge stage 2 reads it (entries 1..6 keep i%4)
    for (int i = 1; i < 6; i++) cyc(0, 6'd0, 1, 1, i[1:0]);
    cyc(1, 6'd7, 1, 1, 2'b10);
    cyc(0, 6'd0, 1, 1, 2'b10);
    check("t4_collide_valid", bus.out_valid, 1);
    check("t4_collide_old", bus.out_data, 3);
    cyc(1, 6'd7, 1, 0, 0);
    cyc(0, 6'd0, 1, 0, 0);
    check("t4_new_value", bus.out_data, 2);

    // 5: asynchronous reset with two items in flight
    cyc(1, 6'd1, 1, 0, 0);
    cyc(1, 6'd2, 1, 0, 0);
    check("t5_inflight_data", bus.out_data, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_async_valid", bus.out_valid, 0);
    check("t5_async_loaded", bus.table_loaded, 0);
    check("t5_async_data", bus.out_data, 0);
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc(0, 6'd0, 1, 0, 0);
      check("t5_quiet", bus.out_valid, 0);
    end
    cyc(1, 6'd7, 1, 0, 0);
    cyc(0, 6'd0, 1, 0, 0);
    check("t5_new_valid", bus.out_valid, 1);
    check("t5_new_gated", bus.out_data, 0);
    cyc(0, 6'd0, 1, 0, 0);
    check("t5_new_drained", bus.out_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
